// File: rtl/pong_game_engine.sv
// pong_game_engine: two-player Pong for a VGA pixel path. It runs a frame-rate
// state machine (serve, play, point, game over) and colours each pixel from it.
module pong_game_engine #(
   parameter int H_MIN        = 144,
   parameter int H_MAX        = 783,
   parameter int V_MIN        = 35,
   parameter int V_MAX        = 515,
   parameter int LP_X         = 155,
   parameter int RP_X         = 762,
   parameter int PADDLE_W     = 10,
   parameter int PADDLE_HALF  = 30,
   parameter int BALL_R       = 10,
   parameter int PADDLE_SPEED = 2,
   parameter int BALL_VX      = 2,
   parameter int BALL_VY      = 1,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 60,
   parameter int WIN_SCORE    = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bright,
   input  logic [9:0]  hCount,
   input  logic [9:0]  vCount,
   input  logic        up1,
   input  logic        down1,
   input  logic        up2,
   input  logic        down2,
   input  logic        start,
   output logic [11:0] rgb,
   output logic [15:0] score,
   output logic        game_over
);

   typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, POINT = 2'd2, OVER = 2'd3} state_t;

   // Signed 11-bit keeps ballx-BALL_R and similar differences from wrapping.
   typedef logic signed [10:0] coord_t;

   localparam coord_t X_MIN     = coord_t'(H_MIN);
   localparam coord_t X_MAX     = coord_t'(H_MAX);
   localparam coord_t Y_MIN     = coord_t'(V_MIN);
   localparam coord_t Y_MAX     = coord_t'(V_MAX);
   localparam coord_t X_CTR     = coord_t'((H_MIN + H_MAX) / 2);
   localparam coord_t Y_CTR     = coord_t'((V_MIN + V_MAX) / 2);
   localparam coord_t B_R       = coord_t'(BALL_R);
   localparam coord_t LP_L      = coord_t'(LP_X);
   localparam coord_t LP_R      = coord_t'(LP_X + PADDLE_W - 1);
   localparam coord_t RP_L      = coord_t'(RP_X);
   localparam coord_t RP_R      = coord_t'(RP_X + PADDLE_W - 1);
   localparam coord_t REACH     = coord_t'(PADDLE_HALF + BALL_R);
   localparam coord_t P_HALF    = coord_t'(PADDLE_HALF);
   localparam coord_t P_ZONE    = coord_t'(PADDLE_HALF / 2);
   localparam coord_t PAD_LO    = coord_t'(V_MIN + PADDLE_HALF);
   localparam coord_t PAD_HI    = coord_t'(V_MAX - PADDLE_HALF);
   localparam coord_t P_SPD     = coord_t'(PADDLE_SPEED);
   localparam coord_t VX_S      = coord_t'(BALL_VX);
   localparam coord_t VY_S      = coord_t'(BALL_VY);
   localparam coord_t LP_BOUNCE = coord_t'(LP_X + PADDLE_W + BALL_R);
   localparam coord_t RP_BOUNCE = coord_t'(RP_X - 1 - BALL_R);
   localparam coord_t MID_LO    = X_CTR - coord_t'(3);
   localparam coord_t MID_HI    = X_CTR + coord_t'(3);

   localparam logic [9:0]  V_BLANK = 10'(V_MAX);
   localparam logic [7:0]  WIN     = 8'(WIN_SCORE);
   localparam int          CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
   localparam int          CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
   localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_FRAMES - 1);

   localparam logic [11:0] BLACK = 12'h000;
   localparam logic [11:0] GREEN = 12'h0F0;
   localparam logic [11:0] RED   = 12'hF00;
   localparam logic [11:0] WHITE = 12'hFFF;
   localparam logic [11:0] BLUE  = 12'h00F;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   state_t           state;
   coord_t           ballx, bally, vx, vy, ypos1, ypos2;
   logic             serve_dir;
   logic [CNT_W-1:0] frame_cnt;
   logic             vb_q;

   logic             vb, tick;
   logic             vx_neg, vx_pos, vy_neg, vy_pos;
   coord_t           ball_l, ball_r;
   logic             goal_l, goal_r, hit_l, hit_r;
   coord_t           nx_ballx, nx_bally, nx_vx, nx_vy;
   logic [7:0]       p1_inc, p2_inc;
   coord_t           h, v;
   logic             on_paddle, on_ball, on_mid;

   function automatic coord_t mag(input coord_t d);
      return d[10] ? -d : d;
   endfunction

   // One paddle step: move per the controls, cancel when both pressed, then clamp.
   function automatic coord_t paddle_step(input coord_t pos, input logic up, input logic down);
      coord_t nxt;
      nxt = pos;
      if (up && !down)
         nxt = pos - P_SPD;
      else if (down && !up)
         nxt = pos + P_SPD;
      if (nxt < PAD_LO)
         nxt = PAD_LO;
      else if (nxt > PAD_HI)
         nxt = PAD_HI;
      return nxt;
   endfunction

   assign vb     = (vCount > V_BLANK);
   assign tick   = vb & ~vb_q;
   assign vx_neg = vx[10];
   assign vx_pos = !vx[10] && (vx != '0);
   assign vy_neg = vy[10];
   assign vy_pos = !vy[10] && (vy != '0);
   assign p1_inc = (score[7:0]  == 8'hFF) ? 8'hFF : score[7:0]  + 8'd1;
   assign p2_inc = (score[15:8] == 8'hFF) ? 8'hFF : score[15:8] + 8'd1;

   // Goal and paddle-contact detection from the pre-tick ball state.
   always_comb begin
      ball_l = ballx - B_R;
      ball_r = ballx + B_R;
      goal_l = (ball_l < X_MIN);
      goal_r = (ball_r > X_MAX);
      hit_l  = vx_neg && (ball_l >= LP_L) && (ball_l <= LP_R) && (mag(bally - ypos1) <= REACH);
      hit_r  = vx_pos && (ball_r >= RP_L) && (ball_r <= RP_R) && (mag(bally - ypos2) <= REACH);
   end

   // Ball position and velocity after one PLAY tick when no goal is scored.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      nx_ballx = ballx + vx;
      nx_vx    = vx;
      nx_bally = bally + vy;
      nx_vy    = vy;
      if ((bally - B_R <= Y_MIN) && vy_neg) begin
         nx_bally = Y_MIN + B_R;
         nx_vy    = VY_S;
      end else if ((bally + B_R >= Y_MAX) && vy_pos) begin
         nx_bally = Y_MAX - B_R;
         nx_vy    = -VY_S;
      end
      if (hit_l) begin
         nx_ballx = LP_BOUNCE;
         nx_vx    = VX_S;
         if (bally < ypos1 - P_ZONE)
            nx_vy = -VY_S;
         else if (bally > ypos1 + P_ZONE)
            nx_vy = VY_S;
      end else if (hit_r) begin
         nx_ballx = RP_BOUNCE;
         nx_vx    = -VX_S;
         if (bally < ypos2 - P_ZONE)
            nx_vy = -VY_S;
         else if (bally > ypos2 + P_ZONE)
            nx_vy = VY_S;
      end
   end

   // Game state machine: serve, play, point and game-over sequencing on frame ticks.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state     <= SERVE;
         ballx     <= X_CTR;
         bally     <= Y_CTR;
         vx        <= '0;
         vy        <= '0;
         ypos1     <= Y_CTR;
         ypos2     <= Y_CTR;
         serve_dir <= DIR_LEFT;
         frame_cnt <= '0;
         score     <= '0;
         game_over <= 1'b0;
         vb_q      <= 1'b0;
      end else begin
         vb_q <= vb;
         if (state == OVER) begin
            if (start) begin
               state     <= SERVE;
               ballx     <= X_CTR;
               bally     <= Y_CTR;
               vx        <= '0;
               vy        <= '0;
               ypos1     <= Y_CTR;
               ypos2     <= Y_CTR;
               serve_dir <= DIR_LEFT;
               frame_cnt <= '0;
               score     <= '0;
               game_over <= 1'b0;
            end
         end else if (tick) begin
            ypos1 <= paddle_step(ypos1, up1, down1);
            ypos2 <= paddle_step(ypos2, up2, down2);
            case (state)
               SERVE: begin
                  if (frame_cnt == SERVE_LAST) begin
                     vx        <= (serve_dir == DIR_RIGHT) ? VX_S : -VX_S;
                     vy        <= '0;
                     frame_cnt <= '0;
                     state     <= PLAY;
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
               PLAY: begin
                  if (goal_l) begin
                     score[15:8] <= p2_inc;
                     serve_dir   <= DIR_LEFT;
                     frame_cnt   <= '0;
                     state       <= (p2_inc == WIN) ? OVER : POINT;
                     game_over   <= (p2_inc == WIN);
                  end else if (goal_r) begin
                     score[7:0] <= p1_inc;
                     serve_dir  <= DIR_RIGHT;
                     frame_cnt  <= '0;
                     state      <= (p1_inc == WIN) ? OVER : POINT;
                     game_over  <= (p1_inc == WIN);
                  end else begin
                     ballx <= nx_ballx;
                     bally <= nx_bally;
                     vx    <= nx_vx;
                     vy    <= nx_vy;
                  end
               end
               POINT: begin
                  if (frame_cnt == POINT_LAST) begin
                     ballx     <= X_CTR;
                     bally     <= Y_CTR;
                     vx        <= '0;
                     vy        <= '0;
                     frame_cnt <= '0;
                     state     <= SERVE;
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign h = $signed({1'b0, hCount});
   assign v = $signed({1'b0, vCount});

   // Pixel colour: blanking, then paddles, ball, midline, background.
   always_comb begin
      on_paddle = ((h >= LP_L) && (h <= LP_R) && (mag(v - ypos1) <= P_HALF)) ||
                  ((h >= RP_L) && (h <= RP_R) && (mag(v - ypos2) <= P_HALF));
      on_ball   = ((state == SERVE) || (state == PLAY)) &&
                  (mag(h - ballx) <= B_R) && (mag(v - bally) <= B_R);
      on_mid    = (h >= MID_LO) && (h <= MID_HI) && (v >= Y_MIN) && (v <= Y_MAX);
      rgb = BLUE;
      if (!bright)
         rgb = BLACK;
      else if (on_paddle)
         rgb = GREEN;
      else if (on_ball)
         rgb = RED;
      else if (on_mid)
         rgb = WHITE;
   end

endmodule

// File: tb/tb_pong_game_engine.sv
// tb_pong_game_engine: directed scenarios for pong_game_engine with a
// queue-based scoreboard. A second instance with WIN_SCORE=1 covers game over.
module tb_pong_game_engine;

   typedef enum int {
      F_BALLX, F_BALLY, F_VX, F_VY, F_YPOS1, F_YPOS2, F_STATE, F_SCORE, F_OVER, F_RGB,
      F_STATE_W, F_SCORE_W, F_OVER_W, F_RGB_W
   } field_t;

   typedef struct {
      string  name;
      field_t field;
      int     expv;
   } exp_t;

   localparam int S_SERVE = 0;
   localparam int S_PLAY  = 1;
   localparam int S_POINT = 2;
   localparam int S_OVER  = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bright = 1'b1;
   logic [9:0]  hCount = '0;
   logic [9:0]  vCount = '0;
   logic        up1 = 1'b0, down1 = 1'b0, up2 = 1'b0, down2 = 1'b0;
   logic        start = 1'b0;
   logic [11:0] rgb, rgb_w;
   logic [15:0] score, score_w;
   logic        game_over, game_over_w;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   pong_game_engine dut (
      .clk(clk), .rst(rst), .bright(bright), .hCount(hCount), .vCount(vCount),
      .up1(up1), .down1(down1), .up2(up2), .down2(down2), .start(start),
      .rgb(rgb), .score(score), .game_over(game_over)
   );

   pong_game_engine #(.WIN_SCORE(1)) dut_w (
      .clk(clk), .rst(rst), .bright(bright), .hCount(hCount), .vCount(vCount),
      .up1(up1), .down1(down1), .up2(up2), .down2(down2), .start(start),
      .rgb(rgb_w), .score(score_w), .game_over(game_over_w)
   );

   function automatic int actual(input field_t f);
      case (f)
         F_BALLX:   return int'(dut.ballx);
         F_BALLY:   return int'(dut.bally);
         F_VX:      return int'(dut.vx);
         F_VY:      return int'(dut.vy);
         F_YPOS1:   return int'(dut.ypos1);
         F_YPOS2:   return int'(dut.ypos2);
         F_STATE:   return int'(dut.state);
         F_SCORE:   return int'(score);
         F_OVER:    return int'(game_over);
         F_RGB:     return int'(rgb);
         F_STATE_W: return int'(dut_w.state);
         F_SCORE_W: return int'(score_w);
         F_OVER_W:  return int'(game_over_w);
         F_RGB_W:   return int'(rgb_w);
         default:   return -99999;
      endcase
   endfunction

   // Monitor: drain expectations against the DUT on each falling edge.
   initial begin
      exp_t e;
      int   got;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = actual(e.field);
            n_vec++;
            if (got !== e.expv) begin
               n_bad++;
               $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", e.name, got, got, e.expv, e.expv);
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input field_t f, input int expv);
      exp_q.push_back('{name, f, expv});
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Each frame tick: vCount enters vertical blank for one clock, then returns.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1 vCount = 10'd520;
         @(posedge clk);
         #1 vCount = 10'd0;
      end
   endtask

   task automatic pix(input string name, input field_t f, input int hx, input int vy_row,
                      input logic br, input int expv);
      hCount = 10'(hx);
      vCount = 10'(vy_row);
      bright = br;
      check(name, f, expv);
      settle();
      vCount = 10'd0;
      bright = 1'b1;
   endtask

   initial begin
      // Reset state and launch / paddle bounces with no input.
      do_reset();
      check("rst_ballx", F_BALLX, 463);
      check("rst_bally", F_BALLY, 275);
      check("rst_vx", F_VX, 0);
      check("rst_vy", F_VY, 0);
      check("rst_ypos1", F_YPOS1, 275);
      check("rst_ypos2", F_YPOS2, 275);
      check("rst_state", F_STATE, S_SERVE);
      check("rst_score", F_SCORE, 0);
      check("rst_over", F_OVER, 0);
      check("rst_score_w", F_SCORE_W, 0);
      settle();
      pix("pix_ball_serve", F_RGB, 463, 275, 1'b1, 12'hF00);
      pix("pix_midline", F_RGB, 463, 300, 1'b1, 12'hFFF);
      pix("pix_paddle1", F_RGB, 160, 275, 1'b1, 12'h0F0);
      pix("pix_background", F_RGB, 300, 100, 1'b1, 12'h00F);
      pix("pix_blank_paddle", F_RGB, 160, 275, 1'b0, 12'h000);

      tick(59);
      check("serve59_state", F_STATE, S_SERVE);
      check("serve59_vx", F_VX, 0);
      settle();
      tick(1);
      check("launch_state", F_STATE, S_PLAY);
      check("launch_vx", F_VX, -2);
      check("launch_ballx", F_BALLX, 463);
      settle();
      tick(145);
      check("pre_lhit_ballx", F_BALLX, 173);
      check("pre_lhit_vx", F_VX, -2);
      settle();
      tick(1);
      check("lhit_ballx", F_BALLX, 175);
      check("lhit_vx", F_VX, 2);
      check("lhit_vy", F_VY, 0);
      settle();
      tick(289);
      check("pre_rhit_ballx", F_BALLX, 753);
      settle();
      tick(1);
      check("rhit_ballx", F_BALLX, 751);
      check("rhit_vx", F_VX, -2);
      settle();
      tick(5);
      check("midplay_state", F_STATE, S_PLAY);
      settle();

      // Reset in the middle of play.
      do_reset();
      check("midrst_ballx", F_BALLX, 463);
      check("midrst_bally", F_BALLY, 275);
      check("midrst_vx", F_VX, 0);
      check("midrst_score", F_SCORE, 0);
      check("midrst_state", F_STATE, S_SERVE);
      settle();

      // up1 held: paddle clamps at 65, ball misses, player 2 scores.
      up1 = 1'b1;
      tick(60);
      check("up1_launch_state", F_STATE, S_PLAY);
      check("up1_ypos1_60", F_YPOS1, 155);
      settle();
      tick(45);
      check("up1_clamp", F_YPOS1, 65);
      settle();
      tick(110);
      check("miss_pre_ballx", F_BALLX, 153);
      check("miss_pre_ypos1", F_YPOS1, 65);
      check("miss_pre_state", F_STATE, S_PLAY);
      check("miss_pre_score", F_SCORE, 0);
      settle();
      pix("pix_ball_play", F_RGB, 153, 275, 1'b1, 12'hF00);
      tick(1);
      up1 = 1'b0;
      check("goal_score", F_SCORE, 16'h0100);
      check("goal_state", F_STATE, S_POINT);
      check("goal_over", F_OVER, 0);
      check("win_score", F_SCORE_W, 16'h0100);
      check("win_state", F_STATE_W, S_OVER);
      check("win_over", F_OVER_W, 1);
      settle();
      pix("pix_hidden_point", F_RGB, 153, 275, 1'b1, 12'h00F);
      pix("pix_hidden_over", F_RGB_W, 153, 275, 1'b1, 12'h00F);

      // start restarts the finished game and is ignored outside game over.
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("start_score_w", F_SCORE_W, 0);
      check("start_state_w", F_STATE_W, S_SERVE);
      check("start_over_w", F_OVER_W, 0);
      check("start_ignored_score", F_SCORE, 16'h0100);
      check("start_ignored_state", F_STATE, S_POINT);
      settle();
      tick(59);
      check("point59_state", F_STATE, S_POINT);
      settle();
      tick(1);
      check("point_end_state", F_STATE, S_SERVE);
      check("point_end_ballx", F_BALLX, 463);
      check("point_end_bally", F_BALLY, 275);
      check("point_end_score", F_SCORE, 16'h0100);
      settle();
      tick(60);
      check("reserve_state", F_STATE, S_PLAY);
      check("reserve_vx_left", F_VX, -2);
      settle();

      // Off-centre hit, top-wall bounce, right-side miss.
      do_reset();
      down1 = 1'b1;
      tick(10);
      down1 = 1'b0;
      check("down1_ypos1", F_YPOS1, 295);
      settle();
      tick(50);
      check("c_launch_vx", F_VX, -2);
      settle();
      tick(145);
      check("c_pre_hit_ballx", F_BALLX, 173);
      check("c_pre_hit_bally", F_BALLY, 275);
      settle();
      tick(1);
      check("c_hit_ballx", F_BALLX, 175);
      check("c_hit_vx", F_VX, 2);
      check("c_hit_vy", F_VY, -1);
      check("c_hit_bally", F_BALLY, 275);
      settle();
      tick(230);
      check("c_wall_bally", F_BALLY, 45);
      check("c_wall_ballx", F_BALLX, 635);
      check("c_wall_vy", F_VY, -1);
      settle();
      tick(1);
      check("c_bounce_bally", F_BALLY, 45);
      check("c_bounce_vy", F_VY, 1);
      check("c_bounce_ballx", F_BALLX, 637);
      settle();
      tick(1);
      check("c_after_bally", F_BALLY, 46);
      settle();
      tick(68);
      check("c_pre_goal_ballx", F_BALLX, 775);
      check("c_pre_goal_score", F_SCORE, 0);
      settle();
      tick(1);
      check("c_goal_score", F_SCORE, 16'h0001);
      check("c_goal_state", F_STATE, S_POINT);
      settle();
      tick(120);
      check("c_reserve_state", F_STATE, S_PLAY);
      check("c_reserve_vx_right", F_VX, 2);
      settle();

      // Opposing controls cancel; right paddle edges; blanking.
      do_reset();
      up2 = 1'b1;
      down2 = 1'b1;
      tick(50);
      check("both2_ypos2", F_YPOS2, 275);
      check("both2_ypos1", F_YPOS1, 275);
      settle();
      pix("pix_p2_top", F_RGB, 762, 245, 1'b1, 12'h0F0);
      pix("pix_p2_above", F_RGB, 762, 244, 1'b1, 12'h00F);
      pix("pix_p2_right_edge", F_RGB, 771, 305, 1'b1, 12'h0F0);
      pix("pix_p2_past_edge", F_RGB, 772, 305, 1'b1, 12'h00F);
      pix("pix_blank_ball", F_RGB, 463, 275, 1'b0, 12'h000);
      pix("pix_blank_p2", F_RGB, 762, 245, 1'b0, 12'h000);
      down2 = 1'b0;
      tick(3);
      up2 = 1'b0;
      check("up2_ypos2", F_YPOS2, 269);
      settle();

      settle();
      if (exp_q.size() != 0) begin
         n_bad += exp_q.size();
         $display("FAIL scoreboard: %0d expectations never compared", exp_q.size());
      end
      if (n_bad == 0)
         $display("PASS: all %0d vectors matched", n_vec);
      else
         $display("FAIL: %0d of %0d vectors miscompared", n_bad, n_vec);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
